// File: rtl/shift_decode_if.sv
// Handshake and shifter-control bundle for shift_decode.
// slave = decoder side, master = producer/consumer side.
interface shift_decode_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_fn;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [9:0]       in_imm;
    logic             in_use_imm;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      sh_op;
    logic [4:0]       sh_amt;
    logic [4:0]       sh_maskbits;
    logic             sh_left;
    logic             sh_sx;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;
    logic             flush;

    modport slave (
        input  in_valid, in_fn, in_a, in_b, in_imm, in_use_imm, in_tag,
        input  out_ready, flush,
        output in_ready, out_valid, sh_op, sh_amt, sh_maskbits,
        output sh_left, sh_sx, out_tag, out_illegal
    );

    modport master (
        output in_valid, in_fn, in_a, in_b, in_imm, in_use_imm, in_tag,
        output out_ready, flush,
        input  in_ready, out_valid, sh_op, sh_amt, sh_maskbits,
        input  sh_left, sh_sx, out_tag, out_illegal
    );
endinterface

// File: rtl/shift_decode.sv
// Shift/bitfield decoder with output register plus one skid entry.
// SHIFT_DECODE_BFX_EN enables UBFX/SBFX (fn 5/6); otherwise they decode illegal.
module shift_decode #(
    parameter int TAG_W = 5
) (
    input logic        clk,
    input logic        rst_n,
    shift_decode_if.slave bus
);
    typedef struct packed {
        logic [31:0]      op;
        logic [4:0]       amt;
        logic [4:0]       mask;
        logic             left;
        logic             sx;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } ent_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t     state, state_nx;
    ent_t       dec, out_q, skid_q;
    logic [4:0] n;
    logic       accept, drain;
    logic       ld_new, ld_skid_out, ld_skid;
    logic       unused_bits;

    assign unused_bits = ^bus.in_b[31:5];

    // Decode the incoming op into a shifter control entry
    always_comb begin
        n        = bus.in_use_imm ? bus.in_imm[4:0] : bus.in_b[4:0];
        dec      = '0;
        dec.op   = bus.in_a;
        dec.tag  = bus.in_tag;
        case (bus.in_fn)
            3'd0: begin
                dec.left = 1'b1;
                dec.amt  = n;
                dec.mask = n;
            end
            3'd1: begin
                dec.amt  = n;
                dec.mask = n;
            end
            3'd2: begin
                dec.amt  = n;
                dec.mask = n;
                dec.sx   = 1'b1;
            end
            3'd3: begin
                dec.amt  = n;
            end
            3'd4: begin
                dec.left = 1'b1;
                dec.amt  = n;
            end
`ifdef SHIFT_DECODE_BFX_EN
            3'd5, 3'd6: begin
                dec.amt  = bus.in_imm[4:0];
                dec.mask = ~bus.in_imm[9:5];
                dec.sx   = (bus.in_fn == 3'd6);
            end
`endif
            default: begin
                dec.ill  = 1'b1;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: flush wins over any accept/drain in the same cycle
    always_comb begin
        state_nx = state;
        case (state)
            EMPTY: if (accept) state_nx = ONE;
            ONE: begin
                if (accept && !drain)      state_nx = TWO;
                else if (drain && !accept) state_nx = EMPTY;
            end
            TWO: if (drain) state_nx = ONE;
            default: state_nx = EMPTY;
        endcase
        if (bus.flush) state_nx = EMPTY;
    end

    // Handshake outputs and datapath load enables, all from state
    always_comb begin
        bus.in_ready  = (state != TWO);
        bus.out_valid = (state != EMPTY);
        accept        = bus.in_valid && (state != TWO);
        drain         = bus.out_ready && (state != EMPTY);
        ld_new        = accept && ((state == EMPTY) || drain);
        ld_skid       = accept && (state == ONE) && !drain;
        ld_skid_out   = drain && (state == TWO);
    end

    // Output and skid registers; cleared on reset and flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
        end else if (bus.flush) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (ld_new)           out_q  <= dec;
            else if (ld_skid_out) out_q  <= skid_q;
            if (ld_skid)          skid_q <= dec;
        end
    end

    assign bus.sh_op       = out_q.op;
    assign bus.sh_amt      = out_q.amt;
    assign bus.sh_maskbits = out_q.mask;
    assign bus.sh_left     = out_q.left;
    assign bus.sh_sx       = out_q.sx;
    assign bus.out_tag     = out_q.tag;
    assign bus.out_illegal = out_q.ill;
endmodule

// File: tb/tb_shift_decode.sv
// Directed bench for shift_decode with a scoreboard of expected bundles.
// Checks decode, ordering, backpressure, flush and async reset.
module tb_shift_decode;
    localparam int TAG_W = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   ntot = 0;
    int   npass = 0;
    int   nfail = 0;
    logic [49:0] sb[$];

    always #5 clk = ~clk;

    shift_decode_if #(.TAG_W(TAG_W)) bus ();

    shift_decode #(.TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string nm, input logic [63:0] obs,
                       input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    // Bundle order: op, amt, mask, left, sx, tag, illegal
    function automatic logic [49:0] model(input logic [2:0] fn,
        input logic [31:0] a, input logic [31:0] b, input logic [9:0] imm,
        input logic use_imm, input logic [TAG_W-1:0] tag);
        logic [4:0] n, amt, mask;
        logic       left, sx, ill;
        n = use_imm ? imm[4:0] : b[4:0];
        amt = 0; mask = 0; left = 0; sx = 0; ill = 0;
        case (fn)
            3'd0: begin left = 1; amt = n; mask = n; end
            3'd1: begin amt = n; mask = n; end
            3'd2: begin amt = n; mask = n; sx = 1; end
            3'd3: amt = n;
            3'd4: begin left = 1; amt = n; end
            3'd5, 3'd6: begin
`ifdef SHIFT_DECODE_BFX_EN
                amt  = imm[4:0];
                mask = 5'd31 - imm[9:5];
                sx   = (fn == 3'd6);
`else
                ill  = 1;
`endif
            end
            default: ill = 1;
        endcase
        return {a, amt, mask, left, sx, tag, ill};
    endfunction

    // Scoreboard: pop on transfer, push on accept, clear on flush/reset
    always @(negedge clk) begin
        if (!rst_n || bus.flush) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0)
                    chk("sb_bundle",
                        64'({bus.sh_op, bus.sh_amt, bus.sh_maskbits,
                             bus.sh_left, bus.sh_sx, bus.out_tag,
                             bus.out_illegal}),
                        64'(sb.pop_front()));
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back(model(bus.in_fn, bus.in_a, bus.in_b,
                                   bus.in_imm, bus.in_use_imm, bus.in_tag));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] fn, input logic [31:0] a,
        input logic [31:0] b, input logic [9:0] imm, input logic ui,
        input logic [TAG_W-1:0] tag);
        bus.in_fn      = fn;
        bus.in_a       = a;
        bus.in_b       = b;
        bus.in_imm     = imm;
        bus.in_use_imm = ui;
        bus.in_tag     = tag;
        bus.in_valid   = 1'b1;
    endtask

    // Drive one op and wait (bounded) for it to be accepted
    task automatic push(input logic [2:0] fn, input logic [31:0] a,
        input logic [31:0] b, input logic [9:0] imm, input logic ui,
        input logic [TAG_W-1:0] tag);
        logic done;
        done = 1'b0;
        drive(fn, a, b, imm, ui, tag);
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            done = bus.in_ready;
            step();
        end
        bus.in_valid = 1'b0;
        chk("accept_in_time", 64'(done), 64'd1);
    endtask

    initial begin
        bus.in_valid = 0; bus.in_fn = 0; bus.in_a = 0; bus.in_b = 0;
        bus.in_imm = 0; bus.in_use_imm = 0; bus.in_tag = 0;
        bus.out_ready = 0; bus.flush = 0;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_sh_op", 64'(bus.sh_op), 64'd0);
        chk("rst_tag_ill", 64'({bus.out_tag, bus.out_illegal}), 64'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // SLL by immediate 4
        bus.out_ready = 1'b1;
        push(3'd0, 32'h0000_00F1, 32'h0, 10'd4, 1'b1, 5'd9);
        chk("sll_valid", 64'(bus.out_valid), 64'd1);
        chk("sll_ctrl", 64'({bus.sh_left, bus.sh_amt, bus.sh_maskbits,
                             bus.sh_sx}), 64'({1'b1, 5'd4, 5'd4, 1'b0}));
        step();

        // SBFX wm1=7 lsb=8
        push(3'd6, 32'h0000_AB00, 32'h0, {5'd7, 5'd8}, 1'b0, 5'd10);
`ifdef SHIFT_DECODE_BFX_EN
        chk("sbfx_ctrl", 64'({bus.out_illegal, bus.sh_left, bus.sh_amt,
                              bus.sh_maskbits, bus.sh_sx}),
            64'({1'b0, 1'b0, 5'd8, 5'd24, 1'b1}));
`else
        chk("sbfx_illegal", 64'({bus.out_illegal, bus.sh_amt,
                                 bus.sh_maskbits, bus.sh_sx}),
            64'({1'b1, 5'd0, 5'd0, 1'b0}));
`endif
        step();

        // Stream 10 ops at one per cycle with constant drain
        for (int i = 0; i < 10; i++) begin
            push(3'(i % 8), $urandom,
                 (i == 0) ? 32'h0000_0020 : $urandom,
                 10'($urandom_range(0, 1023)), (i % 2 == 1), 5'(i + 1));
            chk("stream_in_ready", 64'(bus.in_ready), 64'd1);
            chk("stream_out_valid", 64'(bus.out_valid), 64'd1);
        end
        step(); step();
        chk("stream_drained", 64'(bus.out_valid), 64'd0);

        // Backpressure: two held, third stalled, then in-order release
        bus.out_ready = 1'b0;
        push(3'd1, 32'h1111_1111, 32'd3, 10'd0, 1'b0, 5'd1);
        push(3'd2, 32'h8000_0000, 32'd31, 10'd0, 1'b0, 5'd2);
        chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        drive(3'd4, 32'h3333_3333, 32'd0, 10'd17, 1'b1, 5'd3);
        step(); step();
        chk("bp_head_tag", 64'(bus.out_tag), 64'd1);
        chk("bp_still_full", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        push(3'd4, 32'h3333_3333, 32'd0, 10'd17, 1'b1, 5'd3);
        step(); step(); step();
        chk("bp_all_out", 64'(sb.size()), 64'd0);

        // Flush while full with a valid input pending
        bus.out_ready = 1'b0;
        push(3'd0, 32'hA, 32'd1, 10'd0, 1'b0, 5'd4);
        push(3'd1, 32'hB, 32'd2, 10'd0, 1'b0, 5'd5);
        drive(3'd3, 32'hC, 32'd3, 10'd0, 1'b0, 5'd6);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        step();
        chk("flush_not_captured", 64'(bus.out_valid), 64'd0);

        // Asynchronous reset while full
        bus.out_ready = 1'b0;
        push(3'd2, 32'hDEAD_BEEF, 32'd7, 10'd0, 1'b0, 5'd7);
        push(3'd3, 32'hCAFE_F00D, 32'd9, 10'd0, 1'b0, 5'd8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("arst_bundle", 64'({bus.sh_op, bus.sh_amt, bus.sh_maskbits,
                                bus.sh_left, bus.sh_sx, bus.out_tag,
                                bus.out_illegal}), 64'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // First op after reset goes through normally
        bus.out_ready = 1'b1;
        push(3'd3, 32'h1234_5678, 32'hFFFF_FFE5, 10'd0, 1'b0, 5'd11);
        chk("post_rst_valid", 64'(bus.out_valid), 64'd1);
        chk("post_rst_tag", 64'(bus.out_tag), 64'd11);
        step(); step();
        chk("sb_final_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/shift_decode.md
SHIFT_DECODE -- requirements
Module: shift_decode

Interface
REQ-001 SHALL have parameter TAG_W, default 5, width of the destination-register tag carried with each op.
REQ-002 SHALL have ports clk  in  1  clock, all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports in_valid in 1, in_ready out 1: upstream handshake.
REQ-005 SHALL have ports in_fn in 3 (op code), in_a in 32 (operand), in_b in 32 (register amount), in_imm in 10 (immediate), in_use_imm in 1, in_tag in TAG_W.
REQ-006 SHALL have ports out_valid out 1, out_ready in 1: downstream handshake.
REQ-007 SHALL have ports sh_op out 32, sh_amt out 5, sh_maskbits out 5, sh_left out 1, sh_sx out 1, out_tag out TAG_W, out_illegal out 1: shifter control bundle.
REQ-008 SHALL have port flush in 1: discard all held entries.

Function
REQ-009 SHALL accept an op when in_valid && in_ready; SHALL present it when out_valid; transfer completes when out_valid && out_ready.
REQ-010 SHALL use amount n = in_use_imm ? in_imm[4:0] : in_b[4:0].
REQ-011 Decode, fn 0 SLL: left=1, amt=n, maskbits=n, sx=0.
REQ-012 fn 1 SRL: left=0, amt=n, maskbits=n, sx=0; fn 2 SRA: as SRL with sx=1.
REQ-013 fn 3 ROR: left=0, amt=n, maskbits=0; fn 4 ROL: left=1, amt=n, maskbits=0; sx=0.
REQ-014 fn 5 UBFX: lsb=in_imm[4:0], wm1=in_imm[9:5]; left=0, amt=lsb, maskbits=~wm1 (5-bit), sx=0; fn 6 SBFX: same with sx=1; in_use_imm ignored.
REQ-015 fn 7 SHALL set out_illegal=1 with amt, maskbits, left, sx all 0; sh_op = in_a for every fn.
REQ-016 All 5-bit arithmetic SHALL wrap modulo 32; n=0 yields identity for fn 0-4.
REQ-017 Latency SHALL be one cycle: an op accepted at edge k is on outputs after edge k when output stage was empty or drained that cycle.
REQ-018 Buffering SHALL be an output register plus one skid register; state machine EMPTY, ONE, TWO.
REQ-019 EMPTY: accept -> ONE. ONE: accept without drain -> TWO; drain without accept -> EMPTY; both -> ONE with new op loaded. TWO: drain -> ONE with skid moved to output; no accept possible.
REQ-020 in_ready SHALL be registered, equal to (state != TWO); no combinational path out_ready -> in_ready.
REQ-021 out_valid SHALL equal (state != EMPTY); outputs SHALL hold stable while out_valid && !out_ready.
REQ-022 Order SHALL be strictly FIFO; no op duplicated or lost.
REQ-023 flush SHALL force EMPTY on next edge, overriding simultaneous accept and drain; in_ready=1 after flush.

Reset
REQ-024 On rst_n low SHALL go EMPTY immediately: out_valid=0, in_ready=1, all sh_* outputs, out_tag, out_illegal = 0.
REQ-025 Reset mid-transfer SHALL discard both entries; first op after release is accepted normally.

Configuration
REQ-026 Macro SHIFT_DECODE_BFX_EN: defined -> fn 5/6 decode per REQ-014; undefined -> fn 5/6 treated as fn 7 (out_illegal=1, controls 0); fn 0-4 identical both ways.

Verification
REQ-027 SLL: fn=0, in_a=0x000000F1, use_imm=1, imm=4 -> next cycle sh_left=1, sh_amt=4, sh_maskbits=4, sh_sx=0, out_valid=1.
REQ-028 SBFX with BFX_EN: fn=6, imm={wm1=7,lsb=8}, in_a=0x0000AB00 -> sh_amt=8, sh_maskbits=24, sh_left=0, sh_sx=1; without macro -> out_illegal=1.
REQ-029 Backpressure: out_ready=0, push 3 ops tags 1,2,3 -> tags 1,2 held, in_ready=0 after second, tag 3 stalled; release -> tags 1,2,3 in order.
REQ-030 Simultaneous accept+drain in ONE every cycle for 10 ops -> one op/cycle, state stays ONE, in_ready constant 1.
REQ-031 flush in TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input not captured.
REQ-032 rst_n low while TWO -> out_valid=0, in_ready=1 immediately without clock edge.
